handshake_rr_merge: RTL and testbench
=====================================

# handshake_rr_merge

N-to-1 round-robin merger for `handshake_if` streams: collects entries from up to `NUM_PORTS` upstream senders (typically FIFO `sender` ports) and presents them on a single `handshake_if.sender` through one registered output stage. It sits on the consumer side of the per-lane FIFOs, e.g. several issue/commit lanes draining into one shared downstream pipe. It tags each output beat with the index of its source port.

## Interface
- `NUM_PORTS`, default 4: number of upstream ports; legal range 2..16, need not be a power of two.
- `DATA_WIDTH`, default 32: payload width when `T` is not overridden.
- `T`, default `logic[DATA_WIDTH-1:0]`: payload type.
- `ID_W`, default `$clog2(NUM_PORTS)`: source-index width.
- `clk`  input  1  single clock, all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `receiver[NUM_PORTS]`  `handshake_if.receiver`  T  upstream streams (valid/data in, ready out).
- `sender`  `handshake_if.sender`  T  merged stream (valid/data out, ready in).
- `sender_src`  output  ID_W  source port index of the beat on `sender`, qualified by `sender.valid`.

## Operation
- Transfer on any port: `valid & ready` in the same cycle.
- Output register holds `out_valid_q`, `out_data_q`, `out_src_q`; drives `sender.valid`, `sender.data`, `sender_src` directly, with no combinational path from inputs.
- `load_en = !out_valid_q | sender.ready`: the register can accept a new beat this cycle.
- Grant: among ports with `receiver[i].valid`, pick the first index at or after `rr_ptr`, scanning upward with wrap modulo `NUM_PORTS`. At most one grant per cycle.
- `receiver[i].ready = load_en & grant[i]`. Ready may depend combinationally on input valids and `sender.ready`. Valid never depends on ready.
- On a granted transfer from port i, the output register loads the data with `out_src_q <= i` and `out_valid_q <= 1`, and `rr_ptr <= (i == NUM_PORTS-1) ? 0 : i+1`.
- `load_en` with no input valid: `out_valid_q <= 0`. `rr_ptr` is unchanged.
- `!load_en` (stalled): register, `rr_ptr` and all readies hold; all `receiver[i].ready = 0`.
- Simultaneous output pop and input push in one cycle: the new beat replaces the old. Full throughput is 1 beat/cycle.
- `rr_ptr` width is `ID_W`. Wrap is explicit because `NUM_PORTS` may be non-power-of-two; `rr_ptr` never holds a value ≥ `NUM_PORTS`.
- Data is never dropped or duplicated. Per-port order is preserved.

## Timing
- Reset values: `sender.valid = 0`, `sender.data = '0`, `sender_src = 0`, `rr_ptr = 0`. All `receiver[i].ready = 0` while `rst` is high.
- Reset mid-operation: the beat held in the output register is discarded. Upstream FIFOs are reset by the same `rst` domain.
- Latency: a beat accepted at edge k appears on `sender` after edge k, 1 cycle.
- Fairness: with all ports continuously valid and `sender.ready = 1`, the grant order is 0,1,…,N-1,0,…. Any valid port waits at most `NUM_PORTS-1` transfers.
- A held `sender.valid` with `sender.ready = 0` keeps `sender.data` and `sender_src` stable until the pop.

## Structure
- No new package types. `T` is passed through, and `handshake_if` comes from the existing defines/interface files.
- Natural sub-module: `rr_arbiter`. It holds `rr_ptr` and produces a one-hot grant from `req[NUM_PORTS]` and `advance`. The merge top holds the output register and the data/src mux.

## Test plan
- Reset: hold `rst` 3 cycles with all inputs valid -> all readies 0 and `sender.valid` 0 throughout. First release cycle grants port 0.
- Saturation, N=4: all ports valid, `sender.ready = 1`, data = port*0x100 + seq -> output `sender_src` sequence 0,1,2,3,0,…, one beat per cycle, first output 1 cycle after first grant.
- Backpressure: `sender.ready = 0` for 5 cycles with a beat held (data 0xA5, src 2) -> data and src stable, all readies 0. On release: pop and new load in the same cycle, no bubble.
- Sparse: only port 3 valid, `rr_ptr = 1` -> port 3 granted; `rr_ptr` wraps to 0. Then only port 0 valid -> port 0 granted next.
- Non-power-of-two N=3: 30 random-valid beats -> `rr_ptr` never reaches 3, per-port order is preserved, total in equals total out.
- Mid-stream reset: assert `rst` while `out_valid_q = 1` -> `sender.valid` is 0 on the next cycle, `rr_ptr` is 0, and no held beat appears afterwards.

Source files
------------

// File: rtl/handshake_rr_merge_pkg.sv
// handshake_rr_merge_pkg: shared helpers for the round-robin merger
package handshake_rr_merge_pkg;
  function automatic int wrap_inc(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/handshake_if.sv
// handshake_if: valid/ready stream carrying a payload of type T
interface handshake_if #(parameter type T = logic [31:0]);
  logic valid;
  logic ready;
  T     data;
  modport sender(output valid, data, input ready);
  modport receiver(input valid, data, output ready);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant with explicit modulo wrap of the pointer
module rr_arbiter
  import handshake_rr_merge_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_W = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [ID_W-1:0]      grant_idx
);
  logic [ID_W-1:0] rr_ptr;
  logic found;
  // scan upward from rr_ptr, wrapping at NUM_PORTS, and take the first requester
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        grant_idx = ID_W'(j);
        found = 1'b1;
      end
    end
  end
  // move the pointer just past the winner only when a transfer actually happens
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (advance && found) rr_ptr <= ID_W'(wrap_inc(int'(grant_idx), NUM_PORTS));
  end
endmodule

// File: rtl/handshake_rr_merge.sv
// handshake_rr_merge: N-to-1 round-robin stream merger with one registered output stage
module handshake_rr_merge
  import handshake_rr_merge_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter type T = logic [DATA_WIDTH-1:0],
  parameter int ID_W = $clog2(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  handshake_if.receiver    receiver [NUM_PORTS],
  handshake_if.sender      sender,
  output logic [ID_W-1:0]  sender_src
);
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  T                     din [NUM_PORTS];
  logic [ID_W-1:0]      gidx;
  logic                 out_valid_q;
  T                     out_data_q;
  logic [ID_W-1:0]      out_src_q;
  logic                 load_en;
  assign load_en = !out_valid_q | sender.ready;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign req[i] = receiver[i].valid;
    assign din[i] = receiver[i].data;
    assign receiver[i].ready = load_en & grant[i] & !rst;
  end
  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (load_en),
    .grant     (grant),
    .grant_idx (gidx)
  );
  // output stage: load the granted beat whenever the slot is free or being popped
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (load_en) begin
      out_valid_q <= |req;
      if (|req) begin
        out_data_q <= din[gidx];
        out_src_q  <= gidx;
      end
    end
  end
  assign sender.valid = out_valid_q;
  assign sender.data  = out_data_q;
  assign sender_src   = out_src_q;
endmodule

// File: tb/tb_handshake_rr_merge.sv
// tb_handshake_rr_merge: directed checks of the round-robin merger at N=4 and N=3
module tb_handshake_rr_merge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0]  v4 = 4'hF;
  logic [31:0] d4 [4];
  logic [3:0]  r4;
  logic        rdy4 = 1'b1;
  logic [1:0]  src4;
  logic [2:0]  v3 = 3'b000;
  logic [31:0] d3 [3];
  logic [2:0]  r3;
  logic        rdy3 = 1'b1;
  logic [1:0]  src3;
  handshake_if #(.T(logic [31:0])) rx4 [4] ();
  handshake_if #(.T(logic [31:0])) tx4 ();
  handshake_if #(.T(logic [31:0])) rx3 [3] ();
  handshake_if #(.T(logic [31:0])) tx3 ();
  for (genvar g = 0; g < 4; g++) begin : g_rx4
    assign rx4[g].valid = v4[g];
    assign rx4[g].data  = d4[g];
    assign r4[g] = rx4[g].ready;
  end
  for (genvar g = 0; g < 3; g++) begin : g_rx3
    assign rx3[g].valid = v3[g];
    assign rx3[g].data  = d3[g];
    assign r3[g] = rx3[g].ready;
  end
  assign tx4.ready = rdy4;
  assign tx3.ready = rdy3;
  handshake_rr_merge #(.NUM_PORTS(4)) dut4 (
    .clk(clk), .rst(rst), .receiver(rx4), .sender(tx4), .sender_src(src4)
  );
  handshake_rr_merge #(.NUM_PORTS(3)) dut3 (
    .clk(clk), .rst(rst), .receiver(rx3), .sender(tx3), .sender_src(src3)
  );
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  int seq [4];
  int seq3 [3];
  logic [31:0] q3 [3][$];
  int in_cnt, out_cnt, launched;
  logic [2:0] acc;
  logic pop;
  logic [1:0] psrc;
  logic [31:0] pdata, expd;
  initial begin
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      d4[i] = 32'(i * 256);
    end
    for (int i = 0; i < 3; i++) begin
      seq3[i] = 0;
      d3[i] = 32'(i * 256);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_ready", 64'(r4), 0);
      chk("rst_valid", 64'(tx4.valid), 0);
    end
    chk("rst_data", 64'(tx4.data), 0);
    chk("rst_src", 64'(src4), 0);
    chk("rst_ptr", 64'(dut4.u_arb.rr_ptr), 0);
    rst = 1'b0;
    #1;
    chk("first_grant", 64'(r4), 64'h1);
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("sat_ready", 64'(r4), 64'(1 << (c % 4)));
      step();
      chk("sat_valid", 64'(tx4.valid), 1);
      chk("sat_src", 64'(src4), 64'(c % 4));
      chk("sat_data", 64'(tx4.data), 64'((c % 4) * 256 + seq[c % 4]));
      seq[c % 4]++;
      d4[c % 4] = 32'((c % 4) * 256 + seq[c % 4]);
    end
    v4 = 4'b0100;
    d4[2] = 32'hA5;
    #1;
    chk("bp_load_ready", 64'(r4), 64'h4);
    step();
    chk("bp_load_data", 64'(tx4.data), 64'hA5);
    rdy4 = 1'b0;
    v4 = 4'hF;
    for (int i = 0; i < 4; i++) d4[i] = 32'(i * 256 + 'h50);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 64'(r4), 0);
      step();
      chk("bp_valid", 64'(tx4.valid), 1);
      chk("bp_data", 64'(tx4.data), 64'hA5);
      chk("bp_src", 64'(src4), 2);
    end
    rdy4 = 1'b1;
    #1;
    chk("bp_release_ready", 64'(r4), 64'h8);
    step();
    chk("bp_release_valid", 64'(tx4.valid), 1);
    chk("bp_release_src", 64'(src4), 3);
    chk("bp_release_data", 64'(tx4.data), 64'h350);
    v4 = 4'b0001;
    #1;
    chk("sp_pre_ready", 64'(r4), 64'h1);
    step();
    chk("sp_pre_ptr", 64'(dut4.u_arb.rr_ptr), 1);
    v4 = 4'b1000;
    #1;
    chk("sp3_ready", 64'(r4), 64'h8);
    step();
    chk("sp3_src", 64'(src4), 3);
    chk("sp3_ptr_wrap", 64'(dut4.u_arb.rr_ptr), 0);
    v4 = 4'b0001;
    #1;
    chk("sp0_ready", 64'(r4), 64'h1);
    step();
    chk("sp0_src", 64'(src4), 0);
    chk("sp0_data", 64'(tx4.data), 64'h50);
    v4 = 4'b0000;
    #1;
    step();
    chk("idle_valid", 64'(tx4.valid), 0);
    chk("idle_ptr", 64'(dut4.u_arb.rr_ptr), 1);
    v4 = 4'hF;
    #1;
    step();
    chk("mr_valid_before", 64'(tx4.valid), 1);
    chk("mr_src_before", 64'(src4), 1);
    rdy4 = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_ready", 64'(r4), 0);
    step();
    chk("mr_valid", 64'(tx4.valid), 0);
    chk("mr_ptr", 64'(dut4.u_arb.rr_ptr), 0);
    rst = 1'b0;
    v4 = 4'b0000;
    rdy4 = 1'b1;
    step();
    chk("mr_after1", 64'(tx4.valid), 0);
    step();
    chk("mr_after2", 64'(tx4.valid), 0);
    in_cnt = 0;
    out_cnt = 0;
    launched = 0;
    for (int c = 0; c < 400 && (in_cnt < 30 || out_cnt < in_cnt); c++) begin
      for (int i = 0; i < 3; i++)
        if (!v3[i] && launched < 30 && $urandom_range(0, 1) == 1) begin
          v3[i] = 1'b1;
          launched++;
        end
      rdy3 = $urandom_range(0, 3) != 0;
      #1;
      chk("n3_onehot", 64'($countones(r3) <= 1), 1);
      acc = v3 & r3;
      for (int i = 0; i < 3; i++)
        if (acc[i]) begin
          q3[i].push_back(d3[i]);
          in_cnt++;
        end
      pop = tx3.valid & rdy3;
      psrc = src3;
      pdata = tx3.data;
      step();
      if (pop) begin
        out_cnt++;
        if (psrc > 2 || q3[psrc].size() == 0) chk("n3_unexpected_src", 64'(psrc), 64'hF);
        else begin
          expd = q3[psrc].pop_front();
          chk("n3_order", 64'(pdata), 64'(expd));
        end
      end
      for (int i = 0; i < 3; i++)
        if (acc[i]) begin
          seq3[i]++;
          d3[i] = 32'(i * 256 + seq3[i]);
          v3[i] = 1'b0;
        end
      chk("n3_ptr_range", 64'(dut3.u_arb.rr_ptr < 2'd3), 1);
    end
    chk("n3_total_in", 64'(in_cnt), 30);
    chk("n3_total_out", 64'(out_cnt), 30);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
